// File: rtl/mac_pkg.sv
// Definitions shared by the 32-bit multiply-accumulate unit and the dot-product sequencer.
package mac_pkg;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} mac_seq_state_t;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] bias;
  } mac_cmd_t;

endpackage

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams A/B element pairs through the shared MAC,
// feeding each MAC result back as the next addend, one scalar result per command.
module mac_dot_seq #(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int LEN_W  = mac_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_bias,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_vld,
  output logic              a_rdy,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_vld,
  output logic              b_rdy,
  output logic [DATA_W-1:0] mac_in0,
  output logic [DATA_W-1:0] mac_in1,
  output logic [DATA_W-1:0] mac_in2,
  output logic              mac_in0_vld,
  output logic              mac_in1_vld,
  output logic              mac_in2_vld,
  input  logic              mac_in0_rdy,
  input  logic              mac_in1_rdy,
  input  logic              mac_in2_rdy,
  input  logic [DATA_W-1:0] mac_out0,
  input  logic              mac_out0_vld,
  output logic              mac_out0_rdy,
  output logic [DATA_W-1:0] res_data,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic              busy
);
  import mac_pkg::*;

  mac_seq_state_t    state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              sent0_q, sent0_d;
  logic              sent1_q, sent1_d;
  logic              sent2_q, sent2_d;
  logic              take0, take1, take2;
  mac_cmd_t          cmd;

  assign cmd = '{len: cmd_len, bias: cmd_bias};

  // A channel stops asserting vld once its sent flag is set, so each
  // element is handed to the MAC exactly once even when readies are skewed.
  always_comb begin
    mac_in0      = a_data;
    mac_in1      = b_data;
    mac_in2      = acc_q;
    mac_in0_vld  = (state_q == ISSUE) && a_vld && !sent0_q;
    mac_in1_vld  = (state_q == ISSUE) && b_vld && !sent1_q;
    mac_in2_vld  = (state_q == ISSUE) && !sent2_q;
    a_rdy        = mac_in0_vld && mac_in0_rdy;
    b_rdy        = mac_in1_vld && mac_in1_rdy;
    take0        = a_rdy;
    take1        = b_rdy;
    take2        = mac_in2_vld && mac_in2_rdy;
    cmd_rdy      = (state_q == IDLE);
    mac_out0_rdy = (state_q == WAIT);
    res_vld      = (state_q == DONE);
    res_data     = res_vld ? acc_q : '0;
    busy         = (state_q != IDLE);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    sent0_d = sent0_q;
    sent1_d = sent1_q;
    sent2_d = sent2_q;
    case (state_q)
      IDLE: begin
        if (cmd_vld) begin
          acc_d   = cmd.bias;
          rem_d   = cmd.len;
          state_d = (cmd.len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        sent0_d = sent0_q || take0;
        sent1_d = sent1_q || take1;
        sent2_d = sent2_q || take2;
        if (sent0_d && sent1_d && sent2_d) begin
          sent0_d = 1'b0;
          sent1_d = 1'b0;
          sent2_d = 1'b0;
          state_d = WAIT;
        end
      end
      // Testing for the last element before decrementing keeps a full-scale
      // length from ever wrapping the counter.
      WAIT: begin
        if (mac_out0_vld) begin
          acc_d   = mac_out0;
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? DONE : ISSUE;
        end
      end
      DONE: begin
        if (res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      sent0_q <= 1'b0;
      sent1_q <= 1'b0;
      sent2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      sent0_q <= sent0_d;
      sent1_q <= sent1_d;
      sent2_q <= sent2_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench for mac_dot_seq: a behavioural MAC, queue-fed operand
// sources, a dot-product reference model and a per-cycle compare process.
module tb_mac_dot_seq;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_bias;
  logic          cmd_vld, cmd_rdy;
  logic [DW-1:0] a_data, b_data;
  logic          a_vld, a_rdy, b_vld, b_rdy;
  logic [DW-1:0] mac_in0, mac_in1, mac_in2;
  logic          mac_in0_vld, mac_in1_vld, mac_in2_vld;
  logic          mac_in0_rdy, mac_in1_rdy, mac_in2_rdy;
  logic [DW-1:0] mac_out0;
  logic          mac_out0_vld, mac_out0_rdy;
  logic [DW-1:0] res_data;
  logic          res_vld, res_rdy, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_dot_seq #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_len(cmd_len), .cmd_bias(cmd_bias), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .a_data(a_data), .a_vld(a_vld), .a_rdy(a_rdy),
    .b_data(b_data), .b_vld(b_vld), .b_rdy(b_rdy),
    .mac_in0(mac_in0), .mac_in1(mac_in1), .mac_in2(mac_in2),
    .mac_in0_vld(mac_in0_vld), .mac_in1_vld(mac_in1_vld), .mac_in2_vld(mac_in2_vld),
    .mac_in0_rdy(mac_in0_rdy), .mac_in1_rdy(mac_in1_rdy), .mac_in2_rdy(mac_in2_rdy),
    .mac_out0(mac_out0), .mac_out0_vld(mac_out0_vld), .mac_out0_rdy(mac_out0_rdy),
    .res_data(res_data), .res_vld(res_vld), .res_rdy(res_rdy), .busy(busy)
  );

  // Behavioural MAC: each channel owns a one-entry slot; once all three are
  // filled the result is formed and presented one cycle later (two registers
  // from operand handshake to result). in1_stall forces channel 1 to refuse.
  logic [DW-1:0] slot0, slot1, slot2, out_r;
  logic          full0, full1, full2, out_v;
  int            in1_stall = 0;
  int            mac_ops = 0;

  assign mac_in0_rdy  = !full0;
  assign mac_in1_rdy  = !full1 && (in1_stall == 0);
  assign mac_in2_rdy  = !full2;
  assign mac_out0     = out_r;
  assign mac_out0_vld = out_v;

  always @(posedge clk) begin
    if (!rst_n) begin
      full0 <= 1'b0; full1 <= 1'b0; full2 <= 1'b0;
      out_v <= 1'b0; out_r <= '0;
      slot0 <= '0; slot1 <= '0; slot2 <= '0;
    end else begin
      if (mac_in0_vld && mac_in0_rdy) begin slot0 <= mac_in0; full0 <= 1'b1; end
      if (mac_in1_vld && mac_in1_rdy) begin slot1 <= mac_in1; full1 <= 1'b1; end
      if (mac_in2_vld && mac_in2_rdy) begin slot2 <= mac_in2; full2 <= 1'b1; end
      if (mac_in1_vld && in1_stall > 0) in1_stall <= in1_stall - 1;
      if (full0 && full1 && full2) begin
        out_r   <= slot0 * slot1 + slot2;
        out_v   <= 1'b1;
        full0   <= 1'b0; full1 <= 1'b0; full2 <= 1'b0;
        mac_ops <= mac_ops + 1;
      end else if (out_v && mac_out0_rdy) begin
        out_v <= 1'b0;
      end
    end
  end

  // Operand sources: always valid while their queue holds data, reset with the block.
  logic [DW-1:0] a_src[$];
  logic [DW-1:0] b_src[$];
  int            a_pops = 0;
  int            b_pops = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      a_src.delete();
      b_src.delete();
    end else begin
      if (a_vld && a_rdy) begin void'(a_src.pop_front()); a_pops++; end
      if (b_vld && b_rdy) begin void'(b_src.pop_front()); b_pops++; end
    end
    a_vld  <= (a_src.size() > 0);
    a_data <= (a_src.size() > 0) ? a_src[0] : '0;
    b_vld  <= (b_src.size() > 0);
    b_data <= (b_src.size() > 0) ? b_src[0] : '0;
  end

  // Reference model: expected results in command order.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] stage_a[$];
  logic [DW-1:0] stage_b[$];

  // Compare process: every result shown must match the model, results and
  // MAC operands must stay put while back-pressured, and no command may be
  // offered while a result is pending.
  logic          prev_res_hold = 1'b0, prev_in0_hold = 1'b0, prev_in1_hold = 1'b0;
  logic [DW-1:0] prev_res, prev_in0, prev_in1;
  int            lone_in1 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_res_hold = 1'b0;
      prev_in0_hold = 1'b0;
      prev_in1_hold = 1'b0;
    end else begin
      if (prev_res_hold) begin
        checks++;
        if (!res_vld || res_data !== prev_res) begin
          errors++;
          $display("[TB] FAIL res_hold got vld=%0b data=%h expected vld=1 data=%h", res_vld, res_data, prev_res);
        end
      end
      if (prev_in0_hold) begin
        checks++;
        if (!mac_in0_vld || mac_in0 !== prev_in0) begin
          errors++;
          $display("[TB] FAIL in0_hold got vld=%0b data=%h expected vld=1 data=%h", mac_in0_vld, mac_in0, prev_in0);
        end
      end
      if (prev_in1_hold) begin
        checks++;
        if (!mac_in1_vld || mac_in1 !== prev_in1) begin
          errors++;
          $display("[TB] FAIL in1_hold got vld=%0b data=%h expected vld=1 data=%h", mac_in1_vld, mac_in1, prev_in1);
        end
      end
      if (res_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL res_unexpected got %h expected no result", res_data);
        end else if (res_data !== exp_q[0]) begin
          errors++;
          $display("[TB] FAIL res_model got %h expected %h", res_data, exp_q[0]);
        end
        checks++;
        if (cmd_rdy) begin
          errors++;
          $display("[TB] FAIL cmd_rdy_in_done got 1 expected 0");
        end
        if (res_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (mac_in1_vld && !mac_in1_rdy && !mac_in0_vld && !mac_in2_vld) lone_in1++;
      prev_res_hold = res_vld && !res_rdy;
      prev_res      = res_data;
      prev_in0_hold = mac_in0_vld && !mac_in0_rdy;
      prev_in0      = mac_in0;
      prev_in1_hold = mac_in1_vld && !mac_in1_rdy;
      prev_in1      = mac_in1;
    end
  end

  // Compares one observed value against a hand-computed expectation.
  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Loads the staged vectors into the sources, records the expected dot
  // product and presents the command; returns just after the accepting edge.
  task automatic startCommand(input int len, input logic [DW-1:0] bias);
    logic [DW-1:0] expv;
    int t;
    expv = bias;
    for (int i = 0; i < len; i++) begin
      expv = expv + stage_a[i] * stage_b[i];
      a_src.push_back(stage_a[i]);
      b_src.push_back(stage_b[i]);
    end
    exp_q.push_back(expv);
    @(negedge clk);
    t = 0;
    while (!cmd_rdy && t < 100) begin @(negedge clk); t++; end
    if (!cmd_rdy) begin
      errors++;
      $display("[TB] FAIL cmd_rdy_timeout got 0 expected 1");
    end
    cmd_len  = LW'(len);
    cmd_bias = bias;
    cmd_vld  = 1'b1;
    @(posedge clk);
    #1 cmd_vld = 1'b0;
  endtask

  // Waits for the result (latency counted in cycles after the accepting
  // cycle), optionally back-pressures it, then completes the handshake.
  task automatic awaitResult(input int hold, output int lat, output logic [DW-1:0] data);
    res_rdy = (hold == 0);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!res_vld && lat < 2000);
    if (!res_vld) begin
      errors++;
      $display("[TB] FAIL res_timeout got vld=0 expected vld=1");
    end
    data = res_data;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 res_rdy = 1'b1;
    end
    @(posedge clk);
    #1 res_rdy = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input int len, input logic [DW-1:0] bias,
                               input int hold, input logic [DW-1:0] exp_res, input int exp_lat);
    int lat, a0, b0, m0;
    logic [DW-1:0] data;
    a0 = a_pops; b0 = b_pops; m0 = mac_ops;
    startCommand(len, bias);
    awaitResult(hold, lat, data);
    checkOutput({name, "_res"}, data, exp_res);
    if (exp_lat > 0) checkOutput({name, "_latency"}, DW'(lat), DW'(exp_lat));
    checkOutput({name, "_mac_ops"}, DW'(mac_ops - m0), DW'(len));
    checkOutput({name, "_a_used"}, DW'(a_pops - a0), DW'(len));
    checkOutput({name, "_b_used"}, DW'(b_pops - b0), DW'(len));
    checkOutput({name, "_idle"}, {30'd0, cmd_rdy, busy}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    cmd_len  = '0;
    cmd_bias = '0;
    cmd_vld  = 1'b0;
    res_rdy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_rdy", DW'(cmd_rdy), 32'd1);
    checkOutput("rst_flags", {24'd0, mac_in0_vld, mac_in1_vld, mac_in2_vld, mac_out0_rdy,
                              a_rdy, b_rdy, res_vld, busy}, 32'd0);
    checkOutput("rst_res_data", res_data, 32'd0);
    rst_n = 1'b1;

    $display("[TB] basic dot product");
    stage_a = '{32'd1, 32'd2, 32'd3};
    stage_b = '{32'd4, 32'd5, 32'd6};
    applyStimulus("basic", 3, 32'd10, 0, 32'd42, 10);

    $display("[TB] zero-length command");
    stage_a.delete(); stage_b.delete();
    applyStimulus("zero", 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1);

    // -15 + 0xFFFFFFFE (the truncated 0x7FFFFFFF*2) wraps to 0xFFFFFFEF.
    $display("[TB] signed wrap");
    stage_a = '{32'hFFFFFFFD, 32'h7FFFFFFF};
    stage_b = '{32'd5, 32'd2};
    applyStimulus("wrap", 2, 32'd0, 0, 32'hFFFFFFEF, 7);

    $display("[TB] skewed MAC readies");
    stage_a = '{32'd1, 32'd2, 32'd3};
    stage_b = '{32'd4, 32'd5, 32'd6};
    lone_in1  = 0;
    in1_stall = 4;
    applyStimulus("skew", 3, 32'd10, 0, 32'd42, 0);
    checkOutput("skew_lone_in1_cycles", DW'(lone_in1), 32'd3);

    $display("[TB] result back-pressure");
    stage_a = '{32'd2, 32'd3};
    stage_b = '{32'd4, 32'd5};
    applyStimulus("bp", 2, 32'd1, 5, 32'd24, 7);

    $display("[TB] reset during WAIT");
    stage_a = '{32'd1, 32'd1, 32'd1, 32'd1};
    stage_b = '{32'd9, 32'd9, 32'd9, 32'd9};
    startCommand(4, 32'd5);
    begin
      int t;
      t = 0;
      while (!mac_out0_rdy && t < 100) begin @(negedge clk); t++; end
      checkOutput("rst_wait_reached", DW'(mac_out0_rdy), 32'd1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    checkOutput("midrst_cmd_rdy", DW'(cmd_rdy), 32'd1);
    checkOutput("midrst_flags", {24'd0, mac_in0_vld, mac_in1_vld, mac_in2_vld, mac_out0_rdy,
                                 a_rdy, b_rdy, res_vld, busy}, 32'd0);
    checkOutput("midrst_res_data", res_data, 32'd0);
    #1 rst_n = 1'b1;
    stage_a = '{32'd7};
    stage_b = '{32'd6};
    applyStimulus("after_rst", 1, 32'd0, 0, 32'd42, 4);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
